// File: rtl/timer_pkg.sv
// Shared definitions for the timer family: FSM encoding,
// default prescaler width and the count step function.
package timer_pkg;

  localparam int PRESC_W_DEF = 7;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic       wrap;
    logic [7:0] value;
  } stepRes_t;

  // Up wraps past top to 0, down wraps past 0 to top.
  function automatic stepRes_t stepCount(
    input logic [7:0] cur,
    input logic [7:0] top,
    input logic       down
  );
    stepRes_t r;
    r.wrap  = 1'b0;
    r.value = cur;
    if (down) begin
      if (cur == 8'd0) begin
        r.value = top;
        r.wrap  = 1'b1;
      end else begin
        r.value = cur - 8'd1;
      end
    end else begin
      if (cur >= top) begin
        r.value = 8'd0;
        r.wrap  = 1'b1;
      end else begin
        r.value = cur + 8'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divide-by-2^sel prescaler; step fires when the count
// reaches or passes the limit, so a shrinking sel never stalls.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic       iClk,
  input  logic       iClear,
  input  logic       iRun,
  input  logic [2:0] ivSel,
  output logic       oStep
);

  logic [PRESC_W-1:0] count;
  logic [PRESC_W-1:0] limit;
  logic [PRESC_W:0]   ratio;

  always_comb begin
    ratio = (PRESC_W+1)'(1) << ivSel;
    limit = ratio[PRESC_W-1:0] - PRESC_W'(1);
  end

  assign oStep = iRun && (count >= limit);

  always_ff @(posedge iClk) begin
    if (iClear || !iRun || oStep) begin
      count <= '0;
    end else begin
      count <= count + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/timer8_prescaled.sv
// 8-bit up/down timer with prescaler, load, wrap pulse
// and sticky overflow flag; all outputs registered.
module timer8_prescaled
  import timer_pkg::*;
#(
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic       iClk,
  input  logic       iReset,
  input  logic       iEnable,
  input  logic [2:0] ivPrescaleSel,
  input  logic [7:0] ivPeriod,
  input  logic       iDirDown,
  input  logic       iLoad,
  input  logic [7:0] ivLoadValue,
  input  logic       iOverflowAck,
  output logic [7:0] ovCuenta,
  output logic       oTick,
  output logic       oOverflowPulse,
  output logic       oOverflowFlag,
  output logic       oRunning
);

  state_t   state;
  logic     step;
  logic     clearPresc;
  logic     isRun;
  logic     doStep;
  stepRes_t nxt;

  assign clearPresc = iReset || iLoad;
  assign isRun      = (state == RUN);
  assign doStep     = step && !iLoad;
  assign nxt        = stepCount(ovCuenta, ivPeriod, iDirDown);

  timer_prescaler #(
    .PRESC_W(PRESC_W)
  ) uPresc (
    .iClk  (iClk),
    .iClear(clearPresc),
    .iRun  (isRun),
    .ivSel (ivPrescaleSel),
    .oStep (step)
  );

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state          <= IDLE;
      ovCuenta       <= 8'd0;
      oTick          <= 1'b0;
      oOverflowPulse <= 1'b0;
      oOverflowFlag  <= 1'b0;
      oRunning       <= 1'b0;
    end else begin
      oTick          <= doStep;
      oOverflowPulse <= doStep && nxt.wrap;
      if (iLoad) begin
        ovCuenta <= ivLoadValue;
      end else if (doStep) begin
        ovCuenta <= nxt.value;
      end
      // A wrap in the ack cycle keeps the flag set.
      if (doStep && nxt.wrap) begin
        oOverflowFlag <= 1'b1;
      end else if (iOverflowAck) begin
        oOverflowFlag <= 1'b0;
      end
      if (!iLoad) begin
        state    <= iEnable ? RUN : IDLE;
        oRunning <= iEnable;
      end
    end
  end

endmodule

// File: tb/tb_timer8_prescaled.sv
// Scoreboard bench for timer8_prescaled: cycle model pushes
// expected outputs at each edge, checker pops on the falling edge.
module tb_timer8_prescaled;

  logic       iClk = 1'b0;
  logic       iReset;
  logic       iEnable;
  logic [2:0] ivPrescaleSel;
  logic [7:0] ivPeriod;
  logic       iDirDown;
  logic       iLoad;
  logic [7:0] ivLoadValue;
  logic       iOverflowAck;
  logic [7:0] ovCuenta;
  logic       oTick;
  logic       oOverflowPulse;
  logic       oOverflowFlag;
  logic       oRunning;

  int errCnt = 0;
  int chkCnt = 0;

  typedef struct {
    logic [7:0] cnt;
    bit         tick;
    bit         pulse;
    bit         flag;
    bit         run;
  } exp_t;

  exp_t sbQ[$];
  exp_t sbE;

  always #5 iClk = ~iClk;

  timer8_prescaled dut (
    .iClk          (iClk),
    .iReset        (iReset),
    .iEnable       (iEnable),
    .ivPrescaleSel (ivPrescaleSel),
    .ivPeriod      (ivPeriod),
    .iDirDown      (iDirDown),
    .iLoad         (iLoad),
    .ivLoadValue   (ivLoadValue),
    .iOverflowAck  (iOverflowAck),
    .ovCuenta      (ovCuenta),
    .oTick         (oTick),
    .oOverflowPulse(oOverflowPulse),
    .oOverflowFlag (oOverflowFlag),
    .oRunning      (oRunning)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model
  int         mPresc = 0;
  logic [7:0] mCnt = 8'd0;
  bit         mRun = 0;
  bit         mFlag = 0;
  bit         mTick = 0;
  bit         mPulse = 0;
  bit         mStep = 0;

  always @(posedge iClk) begin
    if (iReset) begin
      mPresc = 0;
      mCnt   = 8'd0;
      mRun   = 0;
      mFlag  = 0;
      mTick  = 0;
      mPulse = 0;
    end else begin
      mStep  = mRun && (mPresc >= (1 << ivPrescaleSel) - 1);
      mTick  = 0;
      mPulse = 0;
      if (iLoad) begin
        mCnt   = ivLoadValue;
        mPresc = 0;
      end else begin
        if (mStep) begin
          mPresc = 0;
          mTick  = 1;
          if (!iDirDown) begin
            if (mCnt >= ivPeriod) begin
              mCnt   = 8'd0;
              mPulse = 1;
            end else begin
              mCnt = mCnt + 8'd1;
            end
          end else begin
            if (mCnt == 8'd0) begin
              mCnt   = ivPeriod;
              mPulse = 1;
            end else begin
              mCnt = mCnt - 8'd1;
            end
          end
        end else begin
          mPresc = mRun ? mPresc + 1 : 0;
        end
        mRun = iEnable;
      end
      if (mPulse) mFlag = 1;
      else if (iOverflowAck) mFlag = 0;
    end
    sbQ.push_back('{mCnt, mTick, mPulse, mFlag, mRun});
  end

  always @(negedge iClk) begin
    if (sbQ.size() > 0) begin
      sbE = sbQ.pop_front();
      chk("sbCuenta", ovCuenta, sbE.cnt);
      chk("sbTick", oTick, sbE.tick);
      chk("sbPulse", oOverflowPulse, sbE.pulse);
      chk("sbFlag", oOverflowFlag, sbE.flag);
      chk("sbRunning", oRunning, sbE.run);
    end
  end

  initial begin
    int seq[4];
    seq = '{1, 2, 3, 0};
    iReset        = 1'b1;
    iEnable       = 1'b0;
    ivPrescaleSel = 3'd0;
    ivPeriod      = 8'd0;
    iDirDown      = 1'b0;
    iLoad         = 1'b0;
    ivLoadValue   = 8'd0;
    iOverflowAck  = 1'b0;

    // Reset with inputs toggling
    repeat (6) begin
      @(negedge iClk);
      iEnable       = 1'($urandom_range(0, 1));
      iLoad         = 1'($urandom_range(0, 1));
      iOverflowAck  = 1'($urandom_range(0, 1));
      iDirDown      = 1'($urandom_range(0, 1));
      ivPrescaleSel = 3'($urandom_range(0, 7));
      ivPeriod      = 8'($urandom_range(0, 255));
      ivLoadValue   = 8'($urandom_range(1, 255));
    end
    @(negedge iClk);
    chk("rstRunning", oRunning, 0);
    chk("rstCuenta", ovCuenta, 0);
    chk("rstFlag", oOverflowFlag, 0);

    // Release: sel 0, period 3, up
    iReset        = 1'b0;
    iEnable       = 1'b1;
    ivPrescaleSel = 3'd0;
    ivPeriod      = 8'd3;
    iDirDown      = 1'b0;
    iLoad         = 1'b0;
    iOverflowAck  = 1'b0;
    @(negedge iClk);
    chk("relRunning", oRunning, 1);
    chk("relCuenta", ovCuenta, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge iClk);
      chk("upSeq", ovCuenta, seq[i]);
      chk("upSeqPulse", oOverflowPulse, (i == 3) ? 1 : 0);
    end

    // sel 2, period 255, from 0
    ivPrescaleSel = 3'd2;
    ivPeriod      = 8'd255;
    iLoad         = 1'b1;
    ivLoadValue   = 8'd0;
    iOverflowAck  = 1'b1;
    @(negedge iClk);
    iLoad        = 1'b0;
    iOverflowAck = 1'b0;
    repeat (3) @(negedge iClk);
    chk("div4Hold", ovCuenta, 0);
    @(negedge iClk);
    chk("div4Step", ovCuenta, 1);
    chk("div4Tick", oTick, 1);
    @(negedge iClk);
    chk("div4TickLow", oTick, 0);
    repeat (15) @(negedge iClk);

    // Down mode, period 5, load 2
    iDirDown      = 1'b1;
    ivPeriod      = 8'd5;
    ivPrescaleSel = 3'd0;
    iLoad         = 1'b1;
    ivLoadValue   = 8'd2;
    @(negedge iClk);
    iLoad = 1'b0;
    chk("dnLoad", ovCuenta, 2);
    @(negedge iClk);
    chk("dn1", ovCuenta, 1);
    @(negedge iClk);
    chk("dn0", ovCuenta, 0);
    chk("dnFlagPre", oOverflowFlag, 0);
    @(negedge iClk);
    chk("dn5", ovCuenta, 5);
    chk("dnFlagSet", oOverflowFlag, 1);
    @(negedge iClk);
    chk("dn4", ovCuenta, 4);
    repeat (3) @(negedge iClk);
    chk("dnFlagHeld", oOverflowFlag, 1);
    iOverflowAck = 1'b1;
    @(negedge iClk);
    iOverflowAck = 1'b0;
    chk("dnFlagAck", oOverflowFlag, 0);

    // Wrap and ack in the same cycle
    iDirDown     = 1'b0;
    ivPeriod     = 8'd0;
    iOverflowAck = 1'b1;
    @(negedge iClk);
    chk("ackWrapFlag", oOverflowFlag, 1);
    chk("ackWrapPulse", oOverflowPulse, 1);
    iOverflowAck = 1'b0;
    iEnable      = 1'b0;
    repeat (2) @(negedge iClk);
    chk("idleRunning", oRunning, 0);
    iOverflowAck = 1'b1;
    @(negedge iClk);
    iOverflowAck = 1'b0;
    chk("ackAlone", oOverflowFlag, 0);

    // Load colliding with a step
    iEnable  = 1'b1;
    ivPeriod = 8'd100;
    repeat (3) @(negedge iClk);
    iLoad       = 1'b1;
    ivLoadValue = 8'd200;
    @(negedge iClk);
    iLoad = 1'b0;
    chk("ldCuenta", ovCuenta, 200);
    chk("ldNoTick", oTick, 0);
    @(negedge iClk);
    chk("ldWrap", ovCuenta, 0);
    chk("ldWrapPulse", oOverflowPulse, 1);

    // sel 7 -> 1 with prescaler at 50
    ivPrescaleSel = 3'd7;
    iLoad         = 1'b1;
    ivLoadValue   = 8'd0;
    @(negedge iClk);
    iLoad = 1'b0;
    repeat (50) @(negedge iClk);
    chk("sel7Hold", ovCuenta, 0);
    ivPrescaleSel = 3'd1;
    @(negedge iClk);
    chk("selDropStep", ovCuenta, 1);
    chk("selDropTick", oTick, 1);
    @(negedge iClk);
    chk("selDropGap", oTick, 0);
    @(negedge iClk);
    chk("selDropNext", ovCuenta, 2);

    // Reset mid-count
    iReset = 1'b1;
    iLoad  = 1'b1;
    @(negedge iClk);
    iReset = 1'b0;
    iLoad  = 1'b0;
    chk("midRstCuenta", ovCuenta, 0);
    chk("midRstRunning", oRunning, 0);
    repeat (6) @(negedge iClk);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      @(negedge iClk);
      iReset        = ($urandom_range(0, 99) == 0);
      iEnable       = ($urandom_range(0, 9) != 0);
      iLoad         = ($urandom_range(0, 19) == 0);
      iOverflowAck  = ($urandom_range(0, 7) == 0);
      ivLoadValue   = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) begin
        iDirDown      = 1'($urandom_range(0, 1));
        ivPrescaleSel = 3'($urandom_range(0, 3));
        ivPeriod      = 8'($urandom_range(0, 12));
      end
    end
    iReset = 1'b0;
    iLoad  = 1'b0;
    repeat (3) @(negedge iClk);
    @(posedge iClk);
    #1;
    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
